// File: rtl/ram_port_arbiter.sv
// Two-port arbiter/sequencer for the single-port data RAM.
// One granted access per two clocks; registered RAM strobes and handshakes.
module ram_port_arbiter #(
  parameter int AW        = 16,
  parameter int DW        = 16,
  parameter int FIXED_PRI = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_ack,
  output logic          a_done,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_ack,
  output logic          b_done,
  output logic [DW-1:0] b_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_read,
  output logic          mem_write,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic {IDLE, ACCESS} state_t;

  localparam bit RR = (FIXED_PRI == 0);

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          we_q, we_d;
  logic          rr_q, rr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          rd_q, rd_d;
  logic          wr_q, wr_d;
  logic          a_ack_q, a_ack_d;
  logic          b_ack_q, b_ack_d;
  logic          a_done_q, a_done_d;
  logic          b_done_q, b_done_d;
  logic [DW-1:0] a_rdata_q, a_rdata_d;
  logic [DW-1:0] b_rdata_q, b_rdata_d;
  logic          pick_b;
  logic          sel_we;

  // owner/rr encoding: 0 = port A, 1 = port B
  always_comb begin
    pick_b = b_req & (~a_req | (RR & rr_q));
    sel_we = pick_b ? b_we : a_we;
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    we_d      = we_q;
    rr_d      = rr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_d      = 1'b0;
    wr_d      = 1'b0;
    a_ack_d   = 1'b0;
    b_ack_d   = 1'b0;
    a_done_d  = 1'b0;
    b_done_d  = 1'b0;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (a_req | b_req) begin
          state_d = ACCESS;
          owner_d = pick_b;
          we_d    = sel_we;
          rr_d    = ~pick_b;
          addr_d  = pick_b ? b_addr : a_addr;
          wdata_d = pick_b ? b_wdata : a_wdata;
          rd_d    = ~sel_we;
          wr_d    = sel_we;
          a_ack_d = ~pick_b;
          b_ack_d = pick_b;
        end
      end
      ACCESS: begin
        state_d  = IDLE;
        a_done_d = ~owner_q;
        b_done_d = owner_q;
        if (!we_q) begin
          if (owner_q) b_rdata_d = mem_rdata;
          else         a_rdata_d = mem_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      rr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      a_done_q  <= 1'b0;
      b_done_q  <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      rr_q      <= rr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      a_ack_q   <= a_ack_d;
      b_ack_q   <= b_ack_d;
      a_done_q  <= a_done_d;
      b_done_q  <= b_done_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  assign a_ack     = a_ack_q;
  assign b_ack     = b_ack_q;
  assign a_done    = a_done_q;
  assign b_done    = b_done_q;
  assign a_rdata   = a_rdata_q;
  assign b_rdata   = b_rdata_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_read  = rd_q;
  assign mem_write = wr_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench: round-robin instance (ports 0/1) and
// fixed-priority instance (ports 2/3), each with its own RAM model.
module tb_ram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req[4];
  logic        we[4];
  logic [15:0] addr[4];
  logic [15:0] wdata[4];
  logic        ack[4];
  logic        done[4];
  logic [15:0] rdata[4];
  logic [15:0] m_addr[2];
  logic [15:0] m_wdata[2];
  logic [15:0] m_rdata[2];
  logic        m_rd[2];
  logic        m_wr[2];
  logic [15:0] ram0[256];
  logic [15:0] ram1[256];
  logic [15:0] addr_cap[2];
  logic [15:0] exp_rd[4];
  logic [15:0] q0[$], q1[$], q2[$], q3[$];
  int          glog0[$], glog1[$], gcyc0[$];
  int          cyc = 0;
  int          wcnt = 0;
  int          vec = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(.AW(16), .DW(16), .FIXED_PRI(0)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .a_req(req[0]), .a_we(we[0]), .a_addr(addr[0]), .a_wdata(wdata[0]),
    .a_ack(ack[0]), .a_done(done[0]), .a_rdata(rdata[0]),
    .b_req(req[1]), .b_we(we[1]), .b_addr(addr[1]), .b_wdata(wdata[1]),
    .b_ack(ack[1]), .b_done(done[1]), .b_rdata(rdata[1]),
    .mem_addr(m_addr[0]), .mem_read(m_rd[0]), .mem_write(m_wr[0]),
    .mem_wdata(m_wdata[0]), .mem_rdata(m_rdata[0])
  );

  ram_port_arbiter #(.AW(16), .DW(16), .FIXED_PRI(1)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .a_req(req[2]), .a_we(we[2]), .a_addr(addr[2]), .a_wdata(wdata[2]),
    .a_ack(ack[2]), .a_done(done[2]), .a_rdata(rdata[2]),
    .b_req(req[3]), .b_we(we[3]), .b_addr(addr[3]), .b_wdata(wdata[3]),
    .b_ack(ack[3]), .b_done(done[3]), .b_rdata(rdata[3]),
    .mem_addr(m_addr[1]), .mem_read(m_rd[1]), .mem_write(m_wr[1]),
    .mem_wdata(m_wdata[1]), .mem_rdata(m_rdata[1])
  );

  assign m_rdata[0] = ram0[m_addr[0][7:0]];
  assign m_rdata[1] = ram1[m_addr[1][7:0]];

  initial begin
    for (int i = 0; i < 256; i++) ram0[i] = 16'h0;
    for (int i = 0; i < 6; i++) ram0[i] = 16'h1000 + 16'(i);
    ram0[8'h10] = 16'h0BAD;
    ram0[8'h20] = 16'h1234;
    ram0[8'h30] = 16'h3A3A;
    ram0[8'h31] = 16'h3B3B;
    ram0[8'h40] = 16'h5555;
    forever begin
      @(posedge clk);
      if (m_wr[0]) ram0[m_addr[0][7:0]] = m_wdata[0];
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) ram1[i] = 16'h0;
    ram1[8'h30] = 16'h3A3A;
    ram1[8'h31] = 16'h3B3B;
    forever begin
      @(posedge clk);
      if (m_wr[1]) ram1[m_addr[1][7:0]] = m_wdata[1];
    end
  end

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic push(input int p, input logic [15:0] v);
    case (p)
      0: q0.push_back(v);
      1: q1.push_back(v);
      2: q2.push_back(v);
      default: q3.push_back(v);
    endcase
  endtask

  function automatic int qsize(input int p);
    case (p)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      default: return q3.size();
    endcase
  endfunction

  function automatic logic [15:0] qpop(input int p);
    case (p)
      0: return q0.pop_front();
      1: return q1.pop_front();
      2: return q2.pop_front();
      default: return q3.pop_front();
    endcase
  endfunction

  task automatic issue(input int p, input logic w, input logic [15:0] ad,
                       input logic [15:0] wd, input logic [15:0] ex);
    bit got;
    got = 1'b0;
    req[p] = 1'b1;
    we[p] = w;
    addr[p] = ad;
    wdata[p] = wd;
    if (!w) exp_rd[p] = ex;
    push(p, exp_rd[p]);
    for (int k = 0; k < 30 && !got; k++) begin
      @(negedge clk);
      got = ack[p];
    end
    if (!got) check($sformatf("ack_timeout_p%0d", p), 0, 1);
    req[p] = 1'b0;
  endtask

  always @(posedge clk) begin
    cyc++;
    #1;
    addr_cap[0] = m_addr[0];
    addr_cap[1] = m_addr[1];
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int p = 0; p < 4; p++) begin
        if (ack[p]) begin
          if (p < 2) begin
            glog0.push_back(p);
            gcyc0.push_back(cyc);
          end else begin
            glog1.push_back(p);
          end
        end
        if (done[p]) begin
          if (qsize(p) == 0) check($sformatf("unexp_done_p%0d", p), 1, 0);
          else check($sformatf("rdata_p%0d", p), {16'h0, rdata[p]},
                     {16'h0, qpop(p)});
        end
      end
      for (int d = 0; d < 2; d++) begin
        if (ack[2*d] | ack[2*d+1])
          check("ack_excl", {31'h0, ack[2*d] & ack[2*d+1]}, 0);
        if (done[2*d] | done[2*d+1])
          check("done_excl", {31'h0, done[2*d] & done[2*d+1]}, 0);
        if (m_rd[d] | m_wr[d]) begin
          check("rd_wr_excl", {31'h0, m_rd[d] & m_wr[d]}, 0);
          check("addr_stable", {16'h0, m_addr[d]}, {16'h0, addr_cap[d]});
        end
      end
      if (m_wr[0]) wcnt++;
    end
  end

  initial begin
    int e3[4];
    int e4[5];
    e3 = '{0, 1, 0, 1};
    e4 = '{2, 2, 2, 2, 3};
    rst_n = 1'b0;
    for (int p = 0; p < 4; p++) begin
      req[p] = 1'b0;
      we[p] = 1'b0;
      addr[p] = 16'h0;
      wdata[p] = 16'h0;
      exp_rd[p] = 16'h0;
    end
    repeat (3) @(negedge clk);
    check("rst_a_ack", {31'h0, ack[0]}, 0);
    check("rst_b_ack", {31'h0, ack[1]}, 0);
    check("rst_a_done", {31'h0, done[0]}, 0);
    check("rst_b_done", {31'h0, done[1]}, 0);
    check("rst_a_rdata", {16'h0, rdata[0]}, 0);
    check("rst_b_rdata", {16'h0, rdata[1]}, 0);
    check("rst_mem_addr", {16'h0, m_addr[0]}, 0);
    check("rst_mem_wdata", {16'h0, m_wdata[0]}, 0);
    check("rst_mem_read", {31'h0, m_rd[0]}, 0);
    check("rst_mem_write", {31'h0, m_wr[0]}, 0);
    rst_n = 1'b1;

    // reset lands in the middle of a B write
    @(negedge clk);
    req[1] = 1'b1;
    we[1] = 1'b1;
    addr[1] = 16'h0010;
    wdata[1] = 16'hDEAD;
    @(negedge clk);
    check("t1_b_ack", {31'h0, ack[1]}, 1);
    check("t1_wr_before", {31'h0, m_wr[0]}, 1);
    rst_n = 1'b0;
    req[1] = 1'b0;
    #1;
    check("t1_wr_abort", {31'h0, m_wr[0]}, 0);
    check("t1_b_ack_clr", {31'h0, ack[1]}, 0);
    check("t1_addr_clr", {16'h0, m_addr[0]}, 0);
    check("t1_wdata_clr", {16'h0, m_wdata[0]}, 0);
    repeat (2) @(negedge clk);
    check("t1_b_done", {31'h0, done[1]}, 0);
    check("t1_ram_kept", {16'h0, ram0[8'h10]}, {16'h0, 16'h0BAD});
    rst_n = 1'b1;

    // simultaneous requests, round-robin
    glog0.delete();
    @(negedge clk);
    fork
      for (int i = 0; i < 2; i++) issue(0, 1'b0, 16'h0030, 16'h0, 16'h3A3A);
      for (int i = 0; i < 2; i++) issue(1, 1'b0, 16'h0031, 16'h0, 16'h3B3B);
    join
    repeat (4) @(negedge clk);
    check("t3_grants", glog0.size(), 4);
    for (int i = 0; i < 4 && i < glog0.size(); i++)
      check($sformatf("t3_grant%0d", i), glog0[i], e3[i]);

    // simultaneous requests, A fixed priority
    glog1.delete();
    fork
      for (int i = 0; i < 4; i++) issue(2, 1'b0, 16'h0030, 16'h0, 16'h3A3A);
      issue(3, 1'b0, 16'h0031, 16'h0, 16'h3B3B);
    join
    repeat (4) @(negedge clk);
    check("t4_grants", glog1.size(), 5);
    for (int i = 0; i < 5 && i < glog1.size(); i++)
      check($sformatf("t4_grant%0d", i), glog1[i], e4[i]);

    // A write then read back
    wcnt = 0;
    issue(0, 1'b1, 16'h0004, 16'hBEEF, 16'h0);
    issue(0, 1'b0, 16'h0004, 16'h0, 16'hBEEF);
    @(negedge clk);
    check("t2_rdata_at_done", {16'h0, rdata[0]}, {16'h0, 16'hBEEF});
    check("t2_done_at_n2", {31'h0, done[0]}, 1);
    repeat (3) @(negedge clk);
    check("t2_write_cycles", wcnt, 1);
    check("t2_ram", {16'h0, ram0[8'h04]}, {16'h0, 16'hBEEF});

    // B read leaves A rdata alone
    issue(0, 1'b0, 16'h0040, 16'h0, 16'h5555);
    repeat (3) @(negedge clk);
    issue(1, 1'b0, 16'h0020, 16'h0, 16'h1234);
    repeat (3) @(negedge clk);
    check("t5_b_rdata", {16'h0, rdata[1]}, {16'h0, 16'h1234});
    check("t5_a_rdata", {16'h0, rdata[0]}, {16'h0, 16'h5555});

    // six back-to-back reads on a held A request
    gcyc0.delete();
    issue(0, 1'b0, 16'h0000, 16'h0, 16'h1000);
    issue(0, 1'b0, 16'h0001, 16'h0, 16'h1001);
    issue(0, 1'b0, 16'h0002, 16'h0, 16'h1002);
    issue(0, 1'b0, 16'h0003, 16'h0, 16'h1003);
    issue(0, 1'b0, 16'h0004, 16'h0, 16'hBEEF);
    issue(0, 1'b0, 16'h0005, 16'h0, 16'h1005);
    repeat (4) @(negedge clk);
    check("t6_grants", gcyc0.size(), 6);
    for (int i = 0; i + 1 < gcyc0.size(); i++)
      check($sformatf("t6_gap%0d", i), gcyc0[i+1] - gcyc0[i], 2);

    for (int p = 0; p < 4; p++)
      check($sformatf("lost_done_p%0d", p), qsize(p), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
